// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bus of the MIPS32 MEM stage: EX/MEM inputs, MEM/WB outputs and the debug read port.
interface mem_stage_if #(
    parameter int BUS_SIZE   = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_enable;
    logic                  i_flush;
    logic                  i_valid;
    logic [BUS_SIZE-1:0]   i_alu_result;
    logic [BUS_SIZE-1:0]   i_store_data;
    logic [4:0]            i_wb_addr;
    logic                  i_mem_read;
    logic                  i_mem_write;
    logic [1:0]            i_mem_size;
    logic                  i_mem_unsigned;
    logic                  i_reg_write;
    logic                  i_mem_to_reg;
    logic [ADDR_WIDTH-1:0] i_debug_addr;
    logic [BUS_SIZE-1:0]   o_mem_data;
    logic [BUS_SIZE-1:0]   o_alu_result;
    logic [4:0]            o_wb_addr;
    logic                  o_reg_write;
    logic                  o_mem_to_reg;
    logic                  o_valid;
    logic                  o_mem_fault;
    logic [BUS_SIZE-1:0]   o_debug_data;

    modport master (
        output i_enable, i_flush, i_valid, i_alu_result, i_store_data, i_wb_addr,
               i_mem_read, i_mem_write, i_mem_size, i_mem_unsigned, i_reg_write,
               i_mem_to_reg, i_debug_addr,
        input  o_mem_data, o_alu_result, o_wb_addr, o_reg_write, o_mem_to_reg,
               o_valid, o_mem_fault, o_debug_data
    );

    modport slave (
        input  i_enable, i_flush, i_valid, i_alu_result, i_store_data, i_wb_addr,
               i_mem_read, i_mem_write, i_mem_size, i_mem_unsigned, i_reg_write,
               i_mem_to_reg, i_debug_addr,
        output o_mem_data, o_alu_result, o_wb_addr, o_reg_write, o_mem_to_reg,
               o_valid, o_mem_fault, o_debug_data
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: little-endian data memory with byte/half/word access, load extension,
// MEM/WB pipeline latch, sticky misalignment flag and a registered debug read port.
module mem_stage #(
    parameter int BUS_SIZE   = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    mem_stage_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [BUS_SIZE-1:0]   r_mem [DEPTH];
    logic [BUS_SIZE-1:0]   r_mem_data;
    logic [BUS_SIZE-1:0]   r_alu_result;
    logic [4:0]            r_wb_addr;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic                  r_valid;
    logic                  r_mem_fault;
    logic [BUS_SIZE-1:0]   r_debug_data;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [BUS_SIZE-1:0]   w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_misaligned;
    logic                  w_sext;
    logic [BUS_SIZE-1:0]   w_load_data;
    logic [3:0]            w_be;
    logic [BUS_SIZE-1:0]   w_wdata;
    logic                  w_store;

    assign w_idx  = bus.i_alu_result[ADDR_WIDTH+1:2];
    assign w_lane = bus.i_alu_result[1:0];
    assign w_word = r_mem[w_idx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.i_mem_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = w_lane[0];
            default: w_misaligned = (w_lane != 2'b00);
        endcase
    end

    always_comb begin
        w_byte = '0;
        case (w_lane)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = '0;
        endcase
    end

    // Asynchronous read: a same-cycle store lands at the edge, so a combined load+store sees the old word.
    always_comb begin
        w_load_data = '0;
        w_sext      = 1'b0;
        if (bus.i_mem_read && !w_misaligned) begin
            case (bus.i_mem_size)
                2'b00: begin
                    w_sext      = !bus.i_mem_unsigned && w_byte[7];
                    w_load_data = {{(BUS_SIZE-8){w_sext}}, w_byte};
                end
                2'b01: begin
                    w_sext      = !bus.i_mem_unsigned && w_half[15];
                    w_load_data = {{(BUS_SIZE-16){w_sext}}, w_half};
                end
                default: w_load_data = w_word;
            endcase
        end
    end

    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        case (bus.i_mem_size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {(BUS_SIZE/8){bus.i_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(BUS_SIZE/16){bus.i_store_data[15:0]}};
            end
            default: begin
                w_be    = '1;
                w_wdata = bus.i_store_data;
            end
        endcase
    end

    // Gating with i_reset keeps a store that coincides with reset assertion out of memory.
    assign w_store = i_reset && bus.i_enable && !bus.i_flush && bus.i_valid &&
                     bus.i_mem_write && !w_misaligned;

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_mem_data   <= '0;
            r_alu_result <= '0;
            r_wb_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
            r_mem_fault  <= 1'b0;
            r_debug_data <= '0;
        end else begin
            r_debug_data <= r_mem[bus.i_debug_addr];
            if (bus.i_enable) begin
                if (bus.i_flush) begin
                    r_valid      <= 1'b0;
                    r_reg_write  <= 1'b0;
                    r_mem_to_reg <= 1'b0;
                end else begin
                    r_mem_data   <= w_load_data;
                    r_alu_result <= bus.i_alu_result;
                    r_wb_addr    <= bus.i_wb_addr;
                    r_valid      <= bus.i_valid;
                    r_reg_write  <= bus.i_valid && bus.i_reg_write;
                    r_mem_to_reg <= bus.i_valid && bus.i_mem_to_reg;
                    if (bus.i_valid && (bus.i_mem_read || bus.i_mem_write) && w_misaligned)
                        r_mem_fault <= 1'b1;
                end
            end
        end
    end

    assign bus.o_mem_data   = r_mem_data;
    assign bus.o_alu_result = r_alu_result;
    assign bus.o_wb_addr    = r_wb_addr;
    assign bus.o_reg_write  = r_reg_write;
    assign bus.o_mem_to_reg = r_mem_to_reg;
    assign bus.o_valid      = r_valid;
    assign bus.o_mem_fault  = r_mem_fault;
    assign bus.o_debug_data = r_debug_data;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a byte-array model.
module tb_mem_stage;
    localparam int BUS_SIZE   = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int NBYTES     = 4 << ADDR_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.BUS_SIZE(BUS_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    mem_stage #(.BUS_SIZE(BUS_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_mem [NBYTES];
    logic [31:0] e_data, e_alu, e_dbg;
    logic [4:0]  e_wb;
    logic        e_regw, e_m2r, e_valid, e_fault;

    function automatic logic [31:0] m_word(input int unsigned a);
        int unsigned b;
        b = (a % NBYTES) & ~32'd3;
        return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model one cycle from the architectural rules, then drive the same inputs across one edge.
    task automatic apply(input logic vld, input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wb, input logic regw, input logic m2r,
                         input logic en, input logic fl, input logic [7:0] dbg);
        int unsigned n, base;
        logic mis;
        logic [31:0] ld;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = addr % NBYTES;
        mis  = (base % n) != 0;
        ld   = '0;
        if (rd && !mis) begin
            for (int unsigned i = 0; i < n; i++) ld |= 32'(m_mem[base+i]) << (8*i);
            if (!uns && n < 4 && ld[8*n-1]) ld |= ~((32'd1 << (8*n)) - 32'd1);
        end
        e_dbg = m_word(32'(dbg) * 4);
        if (en && fl) begin
            e_valid = 1'b0; e_regw = 1'b0; e_m2r = 1'b0;
        end else if (en) begin
            e_data = ld; e_alu = addr; e_wb = wb;
            e_valid = vld; e_regw = vld & regw; e_m2r = vld & m2r;
            if (vld && (rd || wr) && mis) e_fault = 1'b1;
            if (vld && wr && !mis)
                for (int unsigned i = 0; i < n; i++) m_mem[base+i] = data[8*i +: 8];
        end
        bus.i_valid = vld; bus.i_mem_read = rd; bus.i_mem_write = wr;
        bus.i_mem_size = size; bus.i_mem_unsigned = uns; bus.i_alu_result = addr;
        bus.i_store_data = data; bus.i_wb_addr = wb; bus.i_reg_write = regw;
        bus.i_mem_to_reg = m2r; bus.i_enable = en; bus.i_flush = fl; bus.i_debug_addr = dbg;
        tick();
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        apply(1'b1, 1'b0, 1'b1, size, 1'b0, addr, data, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [4:0] wb);
        apply(1'b1, 1'b1, 1'b0, size, uns, addr, 32'd0, wb, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        bus.i_enable = 1'b0; bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_alu_result = '0;
        bus.i_store_data = '0; bus.i_wb_addr = '0; bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        bus.i_mem_size = '0; bus.i_mem_unsigned = 1'b0; bus.i_reg_write = 1'b0;
        bus.i_mem_to_reg = 1'b0; bus.i_debug_addr = '0;
        #1;
        n_checks++; if (bus.o_mem_data !== 32'd0) begin n_errors++; $display("FAIL reset_mem_data: got %h expected 0", bus.o_mem_data); end
        n_checks++; if (bus.o_alu_result !== 32'd0) begin n_errors++; $display("FAIL reset_alu: got %h expected 0", bus.o_alu_result); end
        n_checks++; if ({bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg, bus.o_mem_fault} !== 4'd0) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg, bus.o_mem_fault}); end
        n_checks++; if (bus.o_debug_data !== 32'd0 || bus.o_wb_addr !== 5'd0) begin n_errors++; $display("FAIL reset_dbg_wb: got %h/%h expected 0/0", bus.o_debug_data, bus.o_wb_addr); end
        e_data = '0; e_alu = '0; e_dbg = '0; e_wb = '0;
        e_regw = 1'b0; e_m2r = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int unsigned w = 0; w < (1 << ADDR_WIDTH); w++) st(2'd2, 32'(w * 4), $urandom);
    endtask

    task automatic test_word();
        st(2'd2, 32'h10, 32'hDEADBEEF);
        ld(2'd2, 1'b0, 32'h10, 5'd7);
        n_checks++; if (bus.o_mem_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL word_load: got %h expected deadbeef", bus.o_mem_data); end
        n_checks++; if (bus.o_wb_addr !== 5'd7 || bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL word_wb_valid: got %h/%b expected 07/1", bus.o_wb_addr, bus.o_valid); end
        n_checks++; if (bus.o_alu_result !== 32'h10 || bus.o_reg_write !== 1'b1 || bus.o_mem_to_reg !== 1'b1) begin n_errors++; $display("FAIL word_alu_ctrl: got %h/%b%b expected 10/11", bus.o_alu_result, bus.o_reg_write, bus.o_mem_to_reg); end
    endtask

    task automatic test_byte();
        st(2'd0, 32'h12, 32'h00000080);
        ld(2'd0, 1'b0, 32'h12, 5'd1);
        n_checks++; if (bus.o_mem_data !== 32'hFFFFFF80) begin n_errors++; $display("FAIL byte_signed: got %h expected ffffff80", bus.o_mem_data); end
        ld(2'd0, 1'b1, 32'h12, 5'd2);
        n_checks++; if (bus.o_mem_data !== 32'h00000080) begin n_errors++; $display("FAIL byte_unsigned: got %h expected 00000080", bus.o_mem_data); end
        ld(2'd2, 1'b0, 32'h10, 5'd3);
        n_checks++; if (bus.o_mem_data !== 32'hDE80BEEF) begin n_errors++; $display("FAIL byte_word: got %h expected de80beef", bus.o_mem_data); end
    endtask

    task automatic test_half();
        logic [31:0] w;
        w = m_word(32'h20);
        st(2'd1, 32'h22, 32'h00008001);
        ld(2'd1, 1'b0, 32'h22, 5'd4);
        n_checks++; if (bus.o_mem_data !== 32'hFFFF8001) begin n_errors++; $display("FAIL half_signed: got %h expected ffff8001", bus.o_mem_data); end
        ld(2'd1, 1'b1, 32'h22, 5'd5);
        n_checks++; if (bus.o_mem_data !== 32'h00008001) begin n_errors++; $display("FAIL half_unsigned: got %h expected 00008001", bus.o_mem_data); end
        ld(2'd2, 1'b0, 32'h20, 5'd6);
        n_checks++; if (bus.o_mem_data !== {16'h8001, w[15:0]}) begin n_errors++; $display("FAIL half_word: got %h expected %h", bus.o_mem_data, {16'h8001, w[15:0]}); end
    endtask

    task automatic test_debug();
        apply(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        n_checks++; if (bus.o_debug_data !== 32'hDE80BEEF) begin n_errors++; $display("FAIL debug_read: got %h expected de80beef", bus.o_debug_data); end
        // Debug read colliding with a store returns the pre-write word.
        st(2'd2, 32'h44, 32'h0BADF00D);
        apply(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h13572468, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd17);
        n_checks++; if (bus.o_debug_data !== 32'h0BADF00D) begin n_errors++; $display("FAIL debug_collide: got %h expected 0badf00d", bus.o_debug_data); end
    endtask

    task automatic test_misalign();
        st(2'd2, 32'h13, 32'h11111111);
        n_checks++; if (bus.o_mem_fault !== 1'b1) begin n_errors++; $display("FAIL misalign_fault: got %b expected 1", bus.o_mem_fault); end
        ld(2'd2, 1'b0, 32'h10, 5'd8);
        n_checks++; if (bus.o_mem_data !== 32'hDE80BEEF || bus.o_mem_fault !== 1'b1) begin n_errors++; $display("FAIL misalign_nostore: got %h/%b expected de80beef/1", bus.o_mem_data, bus.o_mem_fault); end
        ld(2'd1, 1'b0, 32'h11, 5'd9);
        n_checks++; if (bus.o_mem_data !== 32'd0 || bus.o_mem_fault !== 1'b1) begin n_errors++; $display("FAIL misalign_load: got %h/%b expected 0/1", bus.o_mem_data, bus.o_mem_fault); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] old, snap_d, snap_a;
        old = m_word(32'h30);
        ld(2'd2, 1'b0, 32'h10, 5'd10);
        snap_d = bus.o_mem_data; snap_a = bus.o_alu_result;
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
            n_checks++; if (bus.o_mem_data !== 32'hDE80BEEF || bus.o_alu_result !== 32'h10 || bus.o_wb_addr !== 5'd10 || bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL stall_hold: got %h/%h/%h/%b expected de80beef/10/0a/1", bus.o_mem_data, bus.o_alu_result, bus.o_wb_addr, bus.o_valid); end
        end
        apply(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        n_checks++; if ({bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg} !== 3'b000) begin n_errors++; $display("FAIL flush_ctrl: got %b expected 000", {bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg}); end
        n_checks++; if (bus.o_mem_data !== snap_d || bus.o_alu_result !== snap_a || bus.o_wb_addr !== 5'd10) begin n_errors++; $display("FAIL flush_hold: got %h/%h/%h expected %h/%h/0a", bus.o_mem_data, bus.o_alu_result, bus.o_wb_addr, snap_d, snap_a); end
        ld(2'd2, 1'b0, 32'h30, 5'd13);
        n_checks++; if (bus.o_mem_data !== old) begin n_errors++; $display("FAIL stall_flush_nostore: got %h expected %h", bus.o_mem_data, old); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pre;
        pre = m_word(32'h40);
        apply(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5AA5A5, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++; if (bus.o_mem_data !== pre) begin n_errors++; $display("FAIL rw_preword: got %h expected %h", bus.o_mem_data, pre); end
        ld(2'd2, 1'b0, 32'h40, 5'd15);
        n_checks++; if (bus.o_mem_data !== 32'h5A5AA5A5) begin n_errors++; $display("FAIL rw_newword: got %h expected 5a5aa5a5", bus.o_mem_data); end
        ld(2'd0, 1'b0, 32'hFFFF_FC43, 5'd16);
        n_checks++; if (bus.o_mem_data !== 32'h0000005A) begin n_errors++; $display("FAIL addr_wrap: got %h expected 0000005a", bus.o_mem_data); end
    endtask

    task automatic test_reset_mid();
        bus.i_valid = 1'b1; bus.i_mem_write = 1'b1; bus.i_mem_read = 1'b0; bus.i_mem_size = 2'd2;
        bus.i_alu_result = 32'h10; bus.i_store_data = 32'h12345678; bus.i_enable = 1'b1; bus.i_flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_mem_data !== 32'd0 || bus.o_alu_result !== 32'd0 || bus.o_wb_addr !== 5'd0) begin n_errors++; $display("FAIL midreset_data: got %h/%h/%h expected 0/0/0", bus.o_mem_data, bus.o_alu_result, bus.o_wb_addr); end
        n_checks++; if ({bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg, bus.o_mem_fault} !== 4'd0 || bus.o_debug_data !== 32'd0) begin n_errors++; $display("FAIL midreset_ctrl: got %b/%h expected 0000/0", {bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg, bus.o_mem_fault}, bus.o_debug_data); end
        tick();
        rst_n = 1'b1;
        e_data = '0; e_alu = '0; e_wb = '0; e_regw = 1'b0; e_m2r = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
        apply(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        n_checks++; if (bus.o_debug_data !== 32'hDE80BEEF) begin n_errors++; $display("FAIL midreset_mem: got %h expected de80beef", bus.o_debug_data); end
        apply(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++; if (bus.o_mem_fault !== 1'b0) begin n_errors++; $display("FAIL fault_invalid: got %b expected 0", bus.o_mem_fault); end
        apply(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        n_checks++; if (bus.o_mem_fault !== 1'b0) begin n_errors++; $display("FAIL fault_flush: got %b expected 0", bus.o_mem_fault); end
        apply(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++; if (bus.o_mem_fault !== 1'b0) begin n_errors++; $display("FAIL fault_stall: got %b expected 0", bus.o_mem_fault); end
        apply(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++; if (bus.o_mem_fault !== 1'b1) begin n_errors++; $display("FAIL fault_set: got %b expected 1", bus.o_mem_fault); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            apply(($urandom % 6) != 0, $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom),
                  $urandom_range(0, 1), (t % 2 == 0) ? ($urandom % 32'h80) : $urandom, $urandom,
                  5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom % 8) != 0, ($urandom % 8) == 0, 8'($urandom % 40));
            n_checks++; if (bus.o_mem_data !== e_data) begin n_errors++; $display("FAIL rnd_mem_data[%0d]: got %h expected %h", t, bus.o_mem_data, e_data); end
            n_checks++; if (bus.o_alu_result !== e_alu || bus.o_wb_addr !== e_wb) begin n_errors++; $display("FAIL rnd_alu_wb[%0d]: got %h/%h expected %h/%h", t, bus.o_alu_result, bus.o_wb_addr, e_alu, e_wb); end
            n_checks++; if ({bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg, bus.o_mem_fault} !== {e_valid, e_regw, e_m2r, e_fault}) begin n_errors++; $display("FAIL rnd_ctrl[%0d]: got %b expected %b", t, {bus.o_valid, bus.o_reg_write, bus.o_mem_to_reg, bus.o_mem_fault}, {e_valid, e_regw, e_m2r, e_fault}); end
            n_checks++; if (bus.o_debug_data !== e_dbg) begin n_errors++; $display("FAIL rnd_debug[%0d]: got %h expected %h", t, bus.o_debug_data, e_dbg); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_debug();
        test_misalign();
        test_stall_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the execute stage and consumes its ALU result, forwarded store data and WB destination. It holds the data memory and performs byte, halfword and word loads and stores. Load data is sign- or zero-extended, and the stage registers its results into the MEM/WB latch for the writeback stage. It also provides a registered word-read port for the debug unit.

Parameters:
BUS_SIZE, 32, datapath width
ADDR_WIDTH, 8, log2 of data memory depth in 32-bit words (256 words)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  pipeline advance; 0 = stall
i_flush  in  1  insert bubble into MEM/WB
i_valid  in  1  instruction in EX/MEM is real
i_alu_result  in  BUS_SIZE  ALU result; also the byte address for loads and stores
i_store_data  in  BUS_SIZE  store data (forwarded B operand)
i_wb_addr  in  5  destination register
i_mem_read  in  1  load
i_mem_write  in  1  store
i_mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_mem_unsigned  in  1  zero-extend loads
i_reg_write  in  1  WB write enable
i_mem_to_reg  in  1  WB selects memory data
i_debug_addr  in  ADDR_WIDTH  debug word index
o_mem_data  out  BUS_SIZE  registered load data
o_alu_result  out  BUS_SIZE  registered ALU result
o_wb_addr  out  5  registered destination
o_reg_write  out  1  registered WB enable
o_mem_to_reg  out  1  registered WB select
o_valid  out  1  registered valid
o_mem_fault  out  1  sticky misalignment flag
o_debug_data  out  BUS_SIZE  registered debug word

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs go to 0, including o_mem_fault and o_debug_data. Memory contents are not reset.
- Addressing: word index = i_alu_result[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap. Byte order is little-endian: lane k = bits [8k+7:8k].
- Misaligned access: a half with addr[0]=1, or a word/reserved access with addr[1:0]!=0.
  - Store is suppressed.
  - Load data = 0.
  - o_mem_fault is set at the edge when i_valid=1 and i_enable=1, and stays set until reset.
- Store: requires i_valid & i_mem_write & i_enable & !misaligned. Memory is written at the rising edge.
  - Byte: i_store_data[7:0] goes to lane addr[1:0].
  - Half: i_store_data[15:0] goes to lanes {addr[1],1} and {addr[1],0}.
  - Word: all 4 lanes.
  - Other lanes are untouched.
- Load: the addressed word is read asynchronously, the byte/half is extracted from the lanes, and the result is extended.
  - Sign extension by default; zero extension when i_mem_unsigned=1.
  - When i_mem_read=0, the captured load data is 0.
- Latency: inputs presented in cycle N appear on the MEM/WB outputs after edge N.
- Store-then-load to the same address in consecutive cycles returns the new data. No bypass is needed because the write completes at edge N.
- i_mem_read and i_mem_write both set: load returns the pre-write word, and the store is still performed.
- Stall (i_enable=0): the MEM/WB outputs hold, no store, no fault update.
- Flush (i_flush=1 with i_enable=1):
  - o_valid, o_reg_write and o_mem_to_reg are loaded with 0; the other MEM/WB outputs hold.
  - The store is suppressed.
  - Flush has priority over a store.
- i_valid=0: behaves like flush for stores and faults. The MEM/WB control outputs are loaded as 0.
- Debug: o_debug_data <= mem[i_debug_addr] every edge, regardless of i_enable or i_flush. It reads the pre-write value when it collides with a store in the same cycle.
- Reset mid-operation: a store coincident with reset assertion must not take effect. Outputs are 0 immediately on reset assertion.

Test Plan:
- Word round-trip: store word 0xDEADBEEF at 0x10, then load word at 0x10 in the next cycle -> o_mem_data=0xDEADBEEF one edge later, o_wb_addr follows its input, o_valid=1.
- Byte lanes:
  - Store byte 0x80 at 0x12 (after the store above), then signed byte load at 0x12 -> 0xFFFFFF80.
  - Unsigned byte load at 0x12 -> 0x00000080.
  - Word load at 0x10 -> 0xDE80BEEF.
- Halfword: store half 0x8001 at 0x22, then signed half load at 0x22 -> 0xFFFF8001; unsigned half load -> 0x00008001; word load at 0x20 -> 0x8001xxxx with the lower half unchanged.
- Misalignment: word store at 0x13 -> memory unchanged, o_mem_fault=1 and stays 1; half load at 0x11 -> o_mem_data=0.
- Stall/flush:
  - i_enable=0 for 3 cycles with a store pending -> outputs frozen, store not performed.
  - i_flush=1 -> o_valid=o_reg_write=o_mem_to_reg=0, target word unchanged.
- Reset and debug:
  - i_debug_addr=4 after the first test -> o_debug_data=0xDE80BEEF next edge.
  - Assert i_reset=0 mid-stream -> all outputs 0 immediately and fault cleared; memory still holds 0xDE80BEEF via the debug port after release.
